// File: rtl/ebpc_stream_checker.sv
// N-channel handshake scoreboard: buffers expected beats, throttles the DUT stream
// with LFSR-driven ready stalls and counts mismatching and accepted beats.
module ebpc_stream_checker #(
   parameter int          NCH        = 3,
   parameter int          DATA_W     = 8,
   parameter int          FIFO_DEPTH = 8,
   parameter int          WAIT_W     = 4,
   parameter int          CNT_W      = 16,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic [WAIT_W-1:0]     cfg_min_wait_i,
   input  logic [WAIT_W-1:0]     cfg_max_wait_i,
   input  logic [NCH*DATA_W-1:0] exp_data_i,
   input  logic [NCH-1:0]        exp_last_i,
   input  logic [NCH-1:0]        exp_vld_i,
   output logic [NCH-1:0]        exp_rdy_o,
   input  logic [NCH*DATA_W-1:0] act_data_i,
   input  logic [NCH-1:0]        act_last_i,
   input  logic [NCH-1:0]        act_vld_i,
   output logic [NCH-1:0]        act_rdy_o,
   output logic [NCH-1:0]        done_o,
   output logic                  all_done_o,
   output logic [NCH*CNT_W-1:0]  err_cnt_o,
   output logic [NCH*CNT_W-1:0]  beat_cnt_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   assign all_done_o = &done_o;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      localparam logic [15:0] SEED_X = SEED ^ 16'(c + 1);
      localparam logic [15:0] SEED_C = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

      logic [DATA_W:0]   mem_q [FIFO_DEPTH];
      logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      state_e            state_q, state_d;
      logic [WAIT_W-1:0] stall_q, stall_d;
      logic [15:0]       lfsr_q, lfsr_d;
      logic [CNT_W-1:0]  err_q, err_d, beat_q, beat_d;
      logic              empty, full, push, pop, mismatch;
      logic [DATA_W:0]   head;
      logic [WAIT_W-1:0] rnd, lim_lo, stall_load;

      // Extra pointer MSB distinguishes full from empty when the indices match.
      assign empty = (wr_ptr_q == rd_ptr_q);
      assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

      assign exp_rdy_o[c] = !rst_i && !full;
      assign act_rdy_o[c] = !rst_i && (state_q == ST_RUN) && !empty && (stall_q == '0);

      assign push     = exp_vld_i[c] && exp_rdy_o[c];
      assign pop      = act_vld_i[c] && act_rdy_o[c];
      assign head     = mem_q[rd_ptr_q[AW-1:0]];
      assign mismatch = (head != {act_last_i[c], act_data_i[c*DATA_W +: DATA_W]});

      // Max is applied last so an inverted min/max pair degrades to max.
      assign rnd        = lfsr_q[WAIT_W-1:0];
      assign lim_lo     = (rnd < cfg_min_wait_i) ? cfg_min_wait_i : rnd;
      assign stall_load = (lim_lo > cfg_max_wait_i) ? cfg_max_wait_i : lim_lo;

      assign done_o[c]                     = !rst_i && (state_q == ST_DONE);
      assign err_cnt_o[c*CNT_W +: CNT_W]  = rst_i ? '0 : err_q;
      assign beat_cnt_o[c*CNT_W +: CNT_W] = rst_i ? '0 : beat_q;

      always_comb begin
         // NOTE: every next-state signal gets its hold value first, so no path
         // through the branches below can leave one unassigned and infer a latch.
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         state_d  = state_q;
         stall_d  = stall_q;
         err_d    = err_q;
         beat_d   = beat_q;
         lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end

         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            stall_d  = stall_load;
            if (beat_q != '1) begin
               beat_d = beat_q + 1'b1;
            end
            if (mismatch && (err_q != '1)) begin
               err_d = err_q + 1'b1;
            end
            if (act_last_i[c]) begin
               state_d = ST_DONE;
            end
         end else if (stall_q != '0) begin
            stall_d = stall_q - 1'b1;
         end
      end

      always_ff @(posedge clk_i) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_RUN;
            stall_q  <= '0;
            err_q    <= '0;
            beat_q   <= '0;
            lfsr_q   <= SEED_C;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            lfsr_q   <= lfsr_d;
         end
      end

      // NOTE: the storage array is not reset; entries are only read once the
      // pointers mark them valid, so clearing the pointers is sufficient.
      always_ff @(posedge clk_i) begin
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {exp_last_i[c], exp_data_i[c*DATA_W +: DATA_W]};
         end
      end
   end

endmodule

// File: tb/tb_ebpc_stream_checker.sv
// Directed bench for ebpc_stream_checker: per-channel beat queues drive both
// sides of each stream; results compared with hand-computed values.
module tb_ebpc_stream_checker;

   localparam int NCH = 3;
   localparam int DW  = 8;
   localparam int CW  = 16;
   localparam int WW  = 4;

   logic              clk_i = 1'b0;
   logic              rst_i, clear_i;
   logic [WW-1:0]     cfg_min_wait_i, cfg_max_wait_i;
   logic [NCH*DW-1:0] exp_data_i, act_data_i;
   logic [NCH-1:0]    exp_last_i, exp_vld_i, exp_rdy_o;
   logic [NCH-1:0]    act_last_i, act_vld_i, act_rdy_o;
   logic [NCH-1:0]    done_o;
   logic              all_done_o;
   logic [NCH*CW-1:0] err_cnt_o, beat_cnt_o;

   ebpc_stream_checker dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_i        (clear_i),
      .cfg_min_wait_i (cfg_min_wait_i),
      .cfg_max_wait_i (cfg_max_wait_i),
      .exp_data_i     (exp_data_i),
      .exp_last_i     (exp_last_i),
      .exp_vld_i      (exp_vld_i),
      .exp_rdy_o      (exp_rdy_o),
      .act_data_i     (act_data_i),
      .act_last_i     (act_last_i),
      .act_vld_i      (act_vld_i),
      .act_rdy_o      (act_rdy_o),
      .done_o         (done_o),
      .all_done_o     (all_done_o),
      .err_cnt_o      (err_cnt_o),
      .beat_cnt_o     (beat_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW:0] exp_mem [NCH][256];
   logic [DW:0] act_mem [NCH][256];
   int          exp_wr [NCH], exp_rd [NCH], act_wr [NCH], act_rd [NCH];
   logic [NCH-1:0] act_en;
   int          xfer_t [256];
   int          n_xfer, rdy_drop;
   int          gaps_a [128];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [CW-1:0] err_of(input int c);
      return err_cnt_o[c*CW +: CW];
   endfunction

   function automatic logic [CW-1:0] beat_of(input int c);
      return beat_cnt_o[c*CW +: CW];
   endfunction

   task automatic flush_queues();
      for (int c = 0; c < NCH; c++) begin
         exp_wr[c] = 0; exp_rd[c] = 0; act_wr[c] = 0; act_rd[c] = 0;
      end
      act_en = '1;
   endtask

   task automatic push_exp(input int c, input logic last, input logic [DW-1:0] d);
      exp_mem[c][exp_wr[c]] = {last, d};
      exp_wr[c]++;
   endtask

   task automatic push_act(input int c, input logic last, input logic [DW-1:0] d);
      act_mem[c][act_wr[c]] = {last, d};
      act_wr[c]++;
   endtask

   function automatic logic drained();
      logic ok = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         if (exp_rd[c] != exp_wr[c]) ok = 1'b0;
         if (act_en[c] && (act_rd[c] != act_wr[c])) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic do_clear();
      exp_vld_i = '0; act_vld_i = '0;
      clear_i = 1'b1;
      cycle();
      clear_i = 1'b0;
      flush_queues();
   endtask

   // Streams all queued beats; records channel-0 transfer cycles.
   task automatic run(input string tag, input int budget);
      int n = 0;
      logic [NCH-1:0] er, ar;
      n_xfer = 0;
      rdy_drop = 0;
      while (!drained() && n < budget) begin
         for (int c = 0; c < NCH; c++) begin
            exp_vld_i[c] = (exp_rd[c] != exp_wr[c]);
            {exp_last_i[c], exp_data_i[c*DW +: DW]} = exp_mem[c][exp_rd[c] % 256];
            act_vld_i[c] = act_en[c] && (act_rd[c] != act_wr[c]);
            {act_last_i[c], act_data_i[c*DW +: DW]} = act_mem[c][act_rd[c] % 256];
         end
         er = exp_rdy_o;
         ar = act_rdy_o;
         if (exp_rd[0] > 0 && act_vld_i[0] && !done_o[0] && !ar[0]) rdy_drop++;
         cycle();
         n++;
         for (int c = 0; c < NCH; c++) begin
            if (exp_vld_i[c] && er[c]) exp_rd[c]++;
            if (act_vld_i[c] && ar[c]) begin
               act_rd[c]++;
               if (c == 0) begin
                  xfer_t[n_xfer] = n;
                  n_xfer++;
               end
            end
         end
      end
      exp_vld_i = '0;
      act_vld_i = '0;
      check({tag, "_drained"}, 32'(drained()), 32'd1);
   endtask

   // Counts gaps outside [lo,hi]; optionally stores/compares the sequence.
   task automatic check_gaps(input string tag, input int lo, input int hi,
                             input int mode);
      int bad = 0;
      int diff = 0;
      int g;
      for (int i = 1; i < n_xfer; i++) begin
         g = xfer_t[i] - xfer_t[i-1] - 1;
         if (g < lo || g > hi) bad++;
         if (mode == 1) gaps_a[i] = g;
         if (mode == 2 && gaps_a[i] != g) diff++;
      end
      check({tag, "_gap_range"}, 32'(bad), 32'd0);
      if (mode == 2) check({tag, "_gap_repeat"}, 32'(diff), 32'd0);
   endtask

   initial begin
      rst_i = 1'b1; clear_i = 1'b0;
      cfg_min_wait_i = '0; cfg_max_wait_i = '0;
      exp_data_i = '0; exp_last_i = '0; exp_vld_i = '0;
      act_data_i = '0; act_last_i = '0; act_vld_i = '0;
      flush_queues();
      cycle();
      cycle();
      check("rst_exp_rdy", 32'(exp_rdy_o), 32'h0);
      check("rst_act_rdy", 32'(act_rdy_o), 32'h0);
      check("rst_done", 32'({all_done_o, done_o}), 32'h0);
      rst_i = 1'b0;
      #1;
      check("post_rst_exp_rdy", 32'(exp_rdy_o), 32'h7);
      check("post_rst_act_rdy", 32'(act_rdy_o), 32'h0);

      // 1: full throughput, clean stream
      push_exp(0, 1'b0, 8'h11); push_exp(0, 1'b0, 8'h22); push_exp(0, 1'b1, 8'h33);
      push_act(0, 1'b0, 8'h11); push_act(0, 1'b0, 8'h22); push_act(0, 1'b1, 8'h33);
      run("t1", 50);
      check("t1_rdy_drop", 32'(rdy_drop), 32'd0);
      check("t1_err", 32'(err_of(0)), 32'd0);
      check("t1_beat", 32'(beat_of(0)), 32'd3);
      check("t1_done", 32'(done_o), 32'b001);
      check("t1_all_done", 32'(all_done_o), 32'd0);
      check("t1_act_rdy_done", 32'(act_rdy_o[0]), 32'd0);

      // 2: data mismatch
      do_clear();
      check("clr_done", 32'(done_o), 32'd0);
      check("clr_beat", 32'(beat_of(0)), 32'd0);
      push_exp(0, 1'b1, 8'hA5);
      push_act(0, 1'b1, 8'h5A);
      run("t2", 50);
      check("t2_err", 32'(err_of(0)), 32'd1);
      check("t2_beat", 32'(beat_of(0)), 32'd1);
      check("t2_done", 32'(done_o[0]), 32'd1);

      // 3: last-flag mismatch ends the channel early
      do_clear();
      push_exp(0, 1'b0, 8'h10); push_exp(0, 1'b1, 8'h20);
      push_act(0, 1'b1, 8'h10);
      run("t3", 50);
      check("t3_err", 32'(err_of(0)), 32'd1);
      check("t3_beat", 32'(beat_of(0)), 32'd1);
      check("t3_done", 32'(done_o[0]), 32'd1);
      check("t3_act_rdy", 32'(act_rdy_o[0]), 32'd0);

      // 4: FIFO full then one pop frees a slot
      do_clear();
      act_en = 3'b000;
      for (int i = 0; i < 8; i++) push_exp(0, 1'b0, 8'(8'h40 + i));
      run("t4a", 50);
      check("t4_full_rdy", 32'(exp_rdy_o[0]), 32'd0);
      check("t4_other_rdy", 32'(exp_rdy_o[2:1]), 32'b11);
      act_en = 3'b001;
      push_act(0, 1'b0, 8'h40);
      run("t4b", 50);
      check("t4_pop_rdy", 32'(exp_rdy_o[0]), 32'd1);
      check("t4_beat", 32'(beat_of(0)), 32'd1);
      check("t4_err", 32'(err_of(0)), 32'd0);

      // 5: random stalls in [2,5], repeatable after clear
      cfg_min_wait_i = 4'd2; cfg_max_wait_i = 4'd5;
      for (int pass = 1; pass <= 2; pass++) begin
         do_clear();
         for (int i = 0; i < 100; i++) begin
            push_exp(0, (i == 99), 8'(i * 3));
            push_act(0, (i == 99), 8'(i * 3));
         end
         run("t5", 2000);
         check("t5_xfers", 32'(n_xfer), 32'd100);
         check_gaps("t5", 2, 5, pass);
         check("t5_err", 32'(err_of(0)), 32'd0);
         check("t5_beat", 32'(beat_of(0)), 32'd100);
      end

      // min > max collapses every stall to max
      cfg_min_wait_i = 4'd5; cfg_max_wait_i = 4'd1;
      do_clear();
      for (int i = 0; i < 10; i++) begin
         push_exp(0, (i == 9), 8'(i));
         push_act(0, (i == 9), 8'(i));
      end
      run("t5b", 200);
      check_gaps("t5b", 1, 1, 0);
      cfg_min_wait_i = '0; cfg_max_wait_i = '0;

      // 6: reset mid-stream discards buffered beats
      do_clear();
      act_en = 3'b000;
      for (int i = 0; i < 4; i++) push_exp(0, 1'b0, 8'(8'h70 + i));
      run("t6a", 50);
      act_en = 3'b001;
      push_act(0, 1'b0, 8'h70);
      run("t6b", 50);
      check("t6_pre_beat", 32'(beat_of(0)), 32'd1);
      rst_i = 1'b1;
      #1;
      check("t6_rst_exp_rdy", 32'(exp_rdy_o), 32'h0);
      check("t6_rst_act_rdy", 32'(act_rdy_o), 32'h0);
      check("t6_rst_beat", 32'(beat_of(0)), 32'd0);
      cycle();
      rst_i = 1'b0;
      #1;
      flush_queues();
      check("t6_empty_after_rst", 32'(act_rdy_o), 32'h0);
      check("t6_beat_after_rst", 32'(beat_of(0)), 32'd0);
      act_en = 3'b101;
      push_exp(0, 1'b0, 8'hC1); push_exp(0, 1'b0, 8'hC2); push_exp(0, 1'b1, 8'hC3);
      push_act(0, 1'b0, 8'hC1); push_act(0, 1'b0, 8'hC2); push_act(0, 1'b1, 8'hC3);
      push_exp(1, 1'b0, 8'hD1); push_exp(1, 1'b1, 8'hD2);
      push_act(1, 1'b0, 8'hD1); push_act(1, 1'b1, 8'hD2);
      run("t6c", 50);
      check("t6_done_ch0_only", 32'(done_o), 32'b001);
      check("t6_err0", 32'(err_of(0)), 32'd0);
      check("t6_beat0", 32'(beat_of(0)), 32'd3);
      check("t6_beat1", 32'(beat_of(1)), 32'd0);
      act_en = 3'b111;
      push_exp(2, 1'b1, 8'hE7);
      push_act(2, 1'b1, 8'hE7);
      run("t6d", 50);
      check("t6_all_done", 32'({all_done_o, done_o}), 32'hF);
      check("t6_err_all", 32'({err_of(1), err_of(2)}), 32'd0);
      check("t6_beat2", 32'(beat_of(2)), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
